// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the LC-3b fetch stage.
// Holds next-PC mux encodings and datapath defaults.
package fetch_stage_pkg;

  localparam int          W_DEF        = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam int          MISS_W       = 8;
  localparam logic [7:0]  MISS_MAX     = 8'hFF;

  typedef enum logic [1:0] {
    PCMUX_NEXT   = 2'd0,
    PCMUX_TARGET = 2'd1,
    PCMUX_TRAP   = 2'd2,
    PCMUX_HOLD   = 2'd3
  } pcmux_e;

  function automatic logic [MISS_W-1:0] sat_inc(
    input logic [MISS_W-1:0] v
  );
    return (v == MISS_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_stage_de_latch.sv
// DE pipeline latch: PC+2, instruction word and valid bit.
// Loads on enable, holds otherwise, cleared by async reset.
module de_latch
  import fetch_stage_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] npc_i,
  input  logic [W-1:0] ir_i,
  input  logic         v_i,
  output logic [W-1:0] npc_o,
  output logic [W-1:0] ir_o,
  output logic         v_o
);

  logic [W-1:0] npc_q, npc_d;
  logic [W-1:0] ir_q, ir_d;
  logic         v_q, v_d;

  always_comb begin
    npc_d = npc_q;
    ir_d  = ir_q;
    v_d   = v_q;
    if (en_i) begin
      npc_d = npc_i;
      ir_d  = ir_i;
      v_d   = v_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      npc_q <= '0;
      ir_q  <= '0;
      v_q   <= 1'b0;
    end else begin
      npc_q <= npc_d;
      ir_q  <= ir_d;
      v_q   <= v_d;
    end
  end

  assign npc_o = npc_q;
  assign ir_o  = ir_q;
  assign v_o   = v_q;

endmodule

// File: rtl/fetch_stage.sv
// LC-3b fetch stage: PC register, next-PC mux, icache miss
// counter and the DE latch that feeds decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int           W        = W_DEF,
  parameter logic [W-1:0] RESET_PC = W'(RESET_PC_DEF)
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [W-1:0] icache_addr,
  output logic         icache_req,
  input  logic         icache_r,
  input  logic [W-1:0] icache_data,
  input  logic         dep_stall,
  input  logic         mem_stall,
  input  logic         v_de_br_stall,
  input  logic         v_agex_br_stall,
  input  logic         v_mem_br_stall,
  input  logic [1:0]   mem_pcmux,
  input  logic [W-1:0] target_pc,
  input  logic [W-1:0] trap_pc,
  output logic [W-1:0] de_npc,
  output logic [W-1:0] de_ir,
  output logic         de_v,
  output logic         fetch_stall
);

  logic [W-1:0]      pc_q, pc_d;
  logic [W-1:0]      pc_plus2;
  logic [W-1:0]      pc_sel;
  logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;

  logic pipe_stall;
  logic br_any;
  logic ld_de;
  logic ld_pc;
  logic redirect;
  logic de_v_in;

  assign pipe_stall = dep_stall | mem_stall;
  assign br_any     = v_de_br_stall | v_agex_br_stall
                    | v_mem_br_stall;
  assign ld_de      = ~pipe_stall;
  assign ld_pc      = icache_r & ~(pipe_stall | br_any);
  assign redirect   = v_mem_br_stall & ~mem_stall;
  assign pc_plus2   = pc_q + W'(2);
  assign de_v_in    = icache_r & ~br_any;

  // Redirect from MEM wins over sequential fetch and
  // abandons any outstanding miss.
  always_comb begin
    pc_sel = pc_q;
    if (redirect) begin
      unique case (pcmux_e'(mem_pcmux))
        PCMUX_NEXT:   pc_sel = pc_plus2;
        PCMUX_TARGET: pc_sel = target_pc;
        PCMUX_TRAP:   pc_sel = trap_pc;
        PCMUX_HOLD:   pc_sel = pc_q;
      endcase
    end else if (ld_pc) begin
      pc_sel = pc_plus2;
    end
    pc_d = {pc_sel[W-1:1], 1'b0};
  end

  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (icache_r) begin
      miss_cnt_d = '0;
    end else if (icache_req) begin
      miss_cnt_d = sat_inc(miss_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      miss_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  de_latch #(
    .W (W)
  ) u_de_latch (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (ld_de),
    .npc_i (pc_plus2),
    .ir_i  (icache_data),
    .v_i   (de_v_in),
    .npc_o (de_npc),
    .ir_o  (de_ir),
    .v_o   (de_v)
  );

  assign icache_addr = pc_q;
  assign icache_req  = rst_n;
  assign fetch_stall = ~icache_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; icache returns addr^A5A5.
// Expected values are hand-derived per step.
module tb_fetch_stage;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] icache_addr;
  logic         icache_req;
  logic         icache_r;
  logic [W-1:0] icache_data;
  logic         dep_stall;
  logic         mem_stall;
  logic         v_de_br_stall;
  logic         v_agex_br_stall;
  logic         v_mem_br_stall;
  logic [1:0]   mem_pcmux;
  logic [W-1:0] target_pc;
  logic [W-1:0] trap_pc;
  logic [W-1:0] de_npc;
  logic [W-1:0] de_ir;
  logic         de_v;
  logic         fetch_stall;

  int n_vec;
  int n_err;

  fetch_stage #(
    .W        (W),
    .RESET_PC (16'h0000)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .icache_addr     (icache_addr),
    .icache_req      (icache_req),
    .icache_r        (icache_r),
    .icache_data     (icache_data),
    .dep_stall       (dep_stall),
    .mem_stall       (mem_stall),
    .v_de_br_stall   (v_de_br_stall),
    .v_agex_br_stall (v_agex_br_stall),
    .v_mem_br_stall  (v_mem_br_stall),
    .mem_pcmux       (mem_pcmux),
    .target_pc       (target_pc),
    .trap_pc         (trap_pc),
    .de_npc          (de_npc),
    .de_ir           (de_ir),
    .de_v            (de_v),
    .fetch_stall     (fetch_stall)
  );

  assign icache_data = icache_addr ^ 16'hA5A5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic clr_br();
    v_de_br_stall   = 1'b0;
    v_agex_br_stall = 1'b0;
    v_mem_br_stall  = 1'b0;
    mem_pcmux       = 2'd0;
  endtask

  task automatic redir(input logic [1:0] sel,
                       input logic [W-1:0] tgt);
    v_mem_br_stall = 1'b1;
    mem_pcmux      = sel;
    target_pc      = tgt;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    icache_r = 1'b1;
    dep_stall = 1'b0;
    mem_stall = 1'b0;
    clr_br();
    target_pc = '0;
    trap_pc = '0;

    // reset state
    tick();
    tick();
    chk("rst_req", 32'(icache_req), 32'h0);
    chk("rst_pc", 32'(icache_addr), 32'h0);
    chk("rst_dev", 32'(de_v), 32'h0);
    chk("rst_npc", 32'(de_npc), 32'h0);
    chk("rst_ir", 32'(de_ir), 32'h0);
    chk("rst_miss", 32'(dut.miss_cnt_q), 32'h0);
    #2 rst_n = 1'b1;
    #1;
    chk("req_on", 32'(icache_req), 32'h1);

    // 1: sequential fetch
    tick();
    chk("seq_pc2", 32'(icache_addr), 32'h2);
    chk("seq_v", 32'(de_v), 32'h1);
    chk("seq_npc2", 32'(de_npc), 32'h2);
    chk("seq_ir0", 32'(de_ir), 32'hA5A5);
    tick();
    chk("seq_pc4", 32'(icache_addr), 32'h4);
    chk("seq_npc4", 32'(de_npc), 32'h4);
    tick();
    chk("seq_pc6", 32'(icache_addr), 32'h6);
    chk("seq_npc6", 32'(de_npc), 32'h6);
    chk("seq_ir4", 32'(de_ir), 32'hA5A1);

    // 2: miss at 3000
    redir(2'd1, 16'h3000);
    tick();
    chk("mis_pc", 32'(icache_addr), 32'h3000);
    chk("mis_bub0", 32'(de_v), 32'h0);
    clr_br();
    icache_r = 1'b0;
    #1;
    chk("mis_fstall", 32'(fetch_stall), 32'h1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("mis_hold", 32'(icache_addr), 32'h3000);
      chk("mis_bub", 32'(de_v), 32'h0);
      chk("mis_cnt", 32'(dut.miss_cnt_q), 32'(i));
    end
    icache_r = 1'b1;
    tick();
    chk("mis_pc_nx", 32'(icache_addr), 32'h3002);
    chk("mis_v", 32'(de_v), 32'h1);
    chk("mis_npc", 32'(de_npc), 32'h3002);
    chk("mis_ir", 32'(de_ir), 32'h95A5);
    chk("mis_clr", 32'(dut.miss_cnt_q), 32'h0);

    // 3: branch at 0010 to 0040
    redir(2'd1, 16'h0010);
    tick();
    clr_br();
    tick();
    chk("br_npc", 32'(de_npc), 32'h0012);
    chk("br_v", 32'(de_v), 32'h1);
    v_de_br_stall = 1'b1;
    tick();
    chk("br_de_pc", 32'(icache_addr), 32'h0012);
    chk("br_de_bub", 32'(de_v), 32'h0);
    v_de_br_stall = 1'b0;
    v_agex_br_stall = 1'b1;
    tick();
    chk("br_ag_pc", 32'(icache_addr), 32'h0012);
    chk("br_ag_bub", 32'(de_v), 32'h0);
    v_agex_br_stall = 1'b0;
    redir(2'd1, 16'h0040);
    tick();
    chk("br_mem_pc", 32'(icache_addr), 32'h0040);
    chk("br_mem_bub", 32'(de_v), 32'h0);
    clr_br();
    tick();
    chk("br_tgt_npc", 32'(de_npc), 32'h0042);
    chk("br_tgt_v", 32'(de_v), 32'h1);

    // 4: trap, bit 0 forced low
    trap_pc = 16'h1201;
    redir(2'd2, 16'h0000);
    tick();
    chk("trap_pc", 32'(icache_addr), 32'h1200);
    chk("trap_bub", 32'(de_v), 32'h0);
    clr_br();
    tick();
    chk("trap_npc", 32'(de_npc), 32'h1202);
    chk("trap_v", 32'(de_v), 32'h1);

    // 5: dep_stall / mem_stall
    dep_stall = 1'b1;
    tick();
    tick();
    chk("dep_pc", 32'(icache_addr), 32'h1202);
    chk("dep_npc", 32'(de_npc), 32'h1202);
    chk("dep_ir", 32'(de_ir), 32'hB7A5);
    chk("dep_v", 32'(de_v), 32'h1);
    mem_stall = 1'b1;
    redir(2'd1, 16'h0200);
    tick();
    chk("ms_pc", 32'(icache_addr), 32'h1202);
    mem_stall = 1'b0;
    tick();
    chk("dr_pc", 32'(icache_addr), 32'h0200);
    chk("dr_npc", 32'(de_npc), 32'h1202);
    chk("dr_v", 32'(de_v), 32'h1);
    dep_stall = 1'b0;
    clr_br();
    tick();
    chk("dr_npc2", 32'(de_npc), 32'h0202);

    // 6: wrap, hold, redirect during miss, reset mid-miss
    redir(2'd1, 16'hFFFE);
    tick();
    chk("wr_pc", 32'(icache_addr), 32'hFFFE);
    clr_br();
    tick();
    chk("wr_pc0", 32'(icache_addr), 32'h0000);
    chk("wr_npc", 32'(de_npc), 32'h0000);
    chk("wr_ir", 32'(de_ir), 32'h5A5B);
    tick();
    redir(2'd3, 16'h0100);
    tick();
    chk("hold_pc", 32'(icache_addr), 32'h0002);
    icache_r = 1'b0;
    redir(2'd0, 16'h0100);
    tick();
    chk("nx_miss_pc", 32'(icache_addr), 32'h0004);
    clr_br();
    tick();
    tick();
    chk("pre_rst_cnt", 32'(dut.miss_cnt_q), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", 32'(icache_addr), 32'h0000);
    chk("arst_v", 32'(de_v), 32'h0);
    chk("arst_cnt", 32'(dut.miss_cnt_q), 32'h0);
    chk("arst_req", 32'(icache_req), 32'h0);
    tick();
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
